// File: rtl/rvm_irq_timer.sv
`default_nettype none
// ============================================================================
// rvm_irq_timer - mtime/mtimecmp/msip interrupt source behind an AXI4-Lite slave.
// Optional macro RVM_IRQ_TIMER_PRESCALER_EN adds the PRESCALE register (0x18).
// Revision: 1.0
// ============================================================================
module rvm_irq_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IRQ    = 3
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic                    ext_irq_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [NUM_IRQ-1:0]      irq_o
);

    localparam logic [4:0] A_MSIP  = 5'h00;
    localparam logic [4:0] A_CMPLO = 5'h08;
    localparam logic [4:0] A_CMPHI = 5'h0C;
    localparam logic [4:0] A_TLO   = 5'h10;
    localparam logic [4:0] A_THI   = 5'h14;
    localparam logic [4:0] A_PRE   = 5'h18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_EXEC = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic addr_mapped(input logic [4:0] a);
        case (a)
            A_MSIP, A_CMPLO, A_CMPHI, A_TLO, A_THI: return 1'b1;
`ifdef RVM_IRQ_TIMER_PRESCALER_EN
            A_PRE: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    logic        rdy_en_q;
    logic [1:0]  wstate_q, wstate_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [4:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [0:0]  rstate_q, rstate_d;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic [1:0]  rresp_q, rresp_d;
    logic        msip_q, msip_d;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [1:0]  ext_sync_q;
    logic [1:0]  irq_q;
    logic        tick;
    logic        w_exec;

    // Readies stay low until the first clock after reset release.
    assign s_axi_awready = rdy_en_q && (wstate_q == W_IDLE) && !aw_done_q;
    assign s_axi_wready  = rdy_en_q && (wstate_q == W_IDLE) && !w_done_q;
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = rdy_en_q && (rstate_q == R_IDLE);
    assign s_axi_rvalid  = (rstate_q == R_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign w_exec = (wstate_q == W_EXEC);

    always_comb begin
        wstate_d  = wstate_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = s_axi_awaddr[4:0];
                end
                if (s_axi_wvalid && s_axi_wready) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if (aw_done_d && w_done_d) wstate_d = W_EXEC;
            end
            W_EXEC: begin
                bresp_d  = addr_mapped(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_d  = W_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

`ifdef RVM_IRQ_TIMER_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d, div_q, div_d;
    logic        wr_pre;

    assign wr_pre = w_exec && (awaddr_q == A_PRE);
    assign tick   = (div_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        if (wr_pre) begin
            if (wstrb_q[0]) prescale_d[7:0]  = wdata_q[7:0];
            if (wstrb_q[1]) prescale_d[15:8] = wdata_q[15:8];
        end
        div_d = (wr_pre || tick) ? 16'd0 : div_q + 16'd1;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prescale_q <= 16'd0;
            div_q      <= 16'd0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A write to either MTIME half replaces that cycle's increment entirely.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (w_exec && awaddr_q == A_TLO)
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata_q, wstrb_q);
        else if (w_exec && awaddr_q == A_THI)
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_q, wstrb_q);
        else if (tick)
            mtime_d = mtime_q + 64'd1;
        if (w_exec && awaddr_q == A_CMPLO)
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wdata_q, wstrb_q);
        if (w_exec && awaddr_q == A_CMPHI)
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_q, wstrb_q);
        if (w_exec && awaddr_q == A_MSIP && wstrb_q[0])
            msip_d = wdata_q[0];
    end

    always_comb begin
        rd_mux = 32'h0;
        case (s_axi_araddr[4:0])
            A_MSIP:  rd_mux = {31'h0, msip_q};
            A_CMPLO: rd_mux = mtimecmp_q[31:0];
            A_CMPHI: rd_mux = mtimecmp_q[63:32];
            A_TLO:   rd_mux = mtime_q[31:0];
            A_THI:   rd_mux = mtime_q[63:32];
`ifdef RVM_IRQ_TIMER_PRESCALER_EN
            A_PRE:   rd_mux = {16'h0, prescale_q};
`endif
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rstate_q == R_IDLE) begin
            if (s_axi_arvalid && s_axi_arready) begin
                rdata_d  = rd_mux;
                rresp_d  = addr_mapped(s_axi_araddr[4:0]) ? RESP_OKAY : RESP_SLVERR;
                rstate_d = R_RESP;
            end
        end else if (s_axi_rready) begin
            rstate_d = R_IDLE;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rdy_en_q   <= 1'b0;
            wstate_q   <= W_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= 5'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            bresp_q    <= 2'b00;
            rstate_q   <= R_IDLE;
            rdata_q    <= 32'h0;
            rresp_q    <= 2'b00;
            msip_q     <= 1'b0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= {64{1'b1}};
            ext_sync_q <= 2'b00;
            irq_q      <= 2'b00;
        end else begin
            rdy_en_q   <= 1'b1;
            wstate_q   <= wstate_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rstate_q   <= rstate_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ext_sync_q <= {ext_sync_q[0], ext_irq_i};
            irq_q      <= {(mtime_q >= mtimecmp_q), msip_q};
        end
    end

    assign irq_o[2:0] = {ext_sync_q[1], irq_q};

    if (NUM_IRQ > 3) begin : g_irq_pad
        assign irq_o[NUM_IRQ-1:3] = '0;
    end

    if (ADDR_WIDTH > 5) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_araddr[ADDR_WIDTH-1:5]};
    end

endmodule
`default_nettype wire

// File: tb/tb_rvm_irq_timer.sv
`default_nettype none
// tb_rvm_irq_timer: scoreboard bench; expected B/R responses are queued at issue time
// and popped by a monitor on each handshake.
module tb_rvm_irq_timer;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_irq = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [2:0]  irq;

    rvm_irq_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_IRQ(3)) dut (
        .clock_i(clk), .reset_ni(rst_n), .ext_irq_i(ext_irq),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    longint unsigned cyc = 0;
    logic [63:0] mt_val = '0;
    longint unsigned mt_cyc = 0;
    longint unsigned last_wr_cyc = 0;
    longint unsigned pre_cyc = 0;
    longint unsigned mtz_cyc = 0;
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];
    logic [33:0] r_e;
    logic [1:0]  b_e;

    // Rising edges seen with reset released; mtime counts the same edges.
    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mt_now();
        return mt_val + 64'(cyc - mt_cyc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && s_axi_rvalid && s_axi_rready) begin
            if (exp_r_q.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                r_e = exp_r_q.pop_front();
                chk("rdata", s_axi_rdata, r_e[33:2]);
                chk("rresp", s_axi_rresp, r_e[1:0]);
            end
        end
        if (rst_n && s_axi_bvalid && s_axi_bready) begin
            if (exp_b_q.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                b_e = exp_b_q.pop_front();
                chk("bresp", s_axi_bresp, b_e);
            end
        end
    end

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp,
                             input int w_lead, input int b_delay);
        bit awd, wd, aw_hs, w_hs;
        int k;
        logic [63:0] old;
        awd = 0;
        wd = 0;
        exp_b_q.push_back(resp);
        tick();
        s_axi_awaddr = {27'h0, addr};
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        if (w_lead == 0) s_axi_awvalid = 1'b1;
        k = 0;
        while (!(awd && wd) && k < 100) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick();
            k++;
            if (aw_hs) begin awd = 1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin wd = 1;  s_axi_wvalid  = 1'b0; end
            if (!awd && !aw_hs && k >= w_lead) s_axi_awvalid = 1'b1;
        end
        if (!(awd && wd)) begin
            chk("aw_w_timeout", 0, 1);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            return;
        end
        k = 0;
        while (!s_axi_bvalid && k < 20) begin tick(); k++; end
        chk("b_latency", 64'(k), 1);
        last_wr_cyc = cyc;
        if (addr == 5'h10 || addr == 5'h14) begin
            old = mt_now() - 64'd1;
            if (addr == 5'h10) mt_val = {old[63:32], merge32(old[31:0], data, strb)};
            else               mt_val = {merge32(old[63:32], data, strb), old[31:0]};
            mt_cyc = cyc;
        end
        for (int i = 0; i < b_delay; i++) begin
            chk("bvalid_hold", s_axi_bvalid, 1);
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    // mode 0: fixed data, 1/2: mtime lo/hi model, 3: prescaled mtime lo
    task automatic axi_read(input logic [4:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input int mode);
        int k;
        logic [63:0] m;
        logic [31:0] e;
        tick();
        s_axi_araddr  = {27'h0, addr};
        s_axi_arvalid = 1'b1;
        k = 0;
        while (!s_axi_arready && k < 50) begin tick(); k++; end
        if (!s_axi_arready) begin
            chk("arready_timeout", 0, 1);
            s_axi_arvalid = 1'b0;
            return;
        end
        m = mt_now();
        e = data;
        if (mode == 1) e = m[31:0];
        else if (mode == 2) e = m[63:32];
        else if (mode == 3) e = 32'((cyc - pre_cyc) / 4 - (mtz_cyc - pre_cyc) / 4);
        exp_r_q.push_back({e, resp});
        tick();
        s_axi_arvalid = 1'b0;
        chk("rvalid_latency", s_axi_rvalid, 1);
        k = 0;
        while (s_axi_rvalid && k < 50) begin tick(); k++; end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_awready", s_axi_awready, 1);
        chk("post_rst_wready", s_axi_wready, 1);
        chk("post_rst_arready", s_axi_arready, 1);
        repeat (99) tick();
        chk("idle_irq", irq, 0);
        axi_read(5'h10, 0, OKAY, 1);
        axi_read(5'h14, 0, OKAY, 2);

        axi_write(5'h00, 1, 4'hF, OKAY, 0, 0);
        chk("msip_irq_set", irq[0], 1);
        axi_read(5'h00, 1, OKAY, 0);
        axi_write(5'h00, 0, 4'h0, OKAY, 0, 0);
        tick();
        chk("msip_strb0_hold", irq[0], 1);
        axi_write(5'h00, 0, 4'h1, OKAY, 0, 0);
        tick();
        chk("msip_irq_clr", irq[0], 0);

        axi_write(5'h0C, 0, 4'hF, OKAY, 0, 0);
        axi_write(5'h08, 50, 4'hF, OKAY, 0, 0);
        axi_write(5'h10, 0, 4'hF, OKAY, 0, 0);
        for (int i = 0; i < 70; i++) begin
            chk("timer_irq", irq[1], 64'((mt_now() - 64'd1) >= 64'd50));
            tick();
        end
        axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF, OKAY, 0, 0);
        tick();
        chk("timer_irq_clr", irq[1], 0);
        axi_write(5'h08, 32'h1234_5678, 4'b0101, OKAY, 0, 0);
        axi_read(5'h08, 32'h0034_0078, OKAY, 0);
        axi_read(5'h0C, 32'hFFFF_FFFF, OKAY, 0);

        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, OKAY, 0, 0);
        axi_write(5'h10, 32'hFFFF_FFFE, 4'hF, OKAY, 0, 0);
        axi_read(5'h10, 0, OKAY, 1);
        axi_read(5'h14, 0, OKAY, 2);
        axi_write(5'h14, 0, 4'hF, OKAY, 0, 0);
        axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, OKAY, 0, 0);
        axi_read(5'h14, 1, OKAY, 2);
        axi_read(5'h10, 0, OKAY, 1);

        fork
            axi_write(5'h00, 1, 4'hF, OKAY, 5, 10);
            begin
                axi_read(5'h00, 0, OKAY, 0);
                axi_read(5'h04, 0, SLVERR, 0);
            end
        join
        chk("msip_after_slow_write", irq[0], 1);
        axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF, SLVERR, 0, 0);

        tick();
        ext_irq = 1'b1;
        tick();
        chk("ext_rise_early", irq[2], 0);
        tick();
        tick();
        chk("ext_rise", irq[2], 1);
        ext_irq = 1'b0;
        tick();
        chk("ext_fall_early", irq[2], 1);
        tick();
        tick();
        chk("ext_fall", irq[2], 0);

`ifdef RVM_IRQ_TIMER_PRESCALER_EN
        axi_write(5'h18, 3, 4'hF, OKAY, 0, 0);
        pre_cyc = last_wr_cyc;
        axi_read(5'h18, 3, OKAY, 0);
        axi_write(5'h14, 0, 4'hF, OKAY, 0, 0);
        axi_write(5'h10, 0, 4'hF, OKAY, 0, 0);
        mtz_cyc = last_wr_cyc;
        repeat (13) tick();
        axi_read(5'h10, 0, OKAY, 3);
        repeat (5) tick();
        axi_read(5'h10, 0, OKAY, 3);
        axi_read(5'h14, 0, OKAY, 0);
`else
        axi_read(5'h18, 0, SLVERR, 0);
        axi_write(5'h18, 5, 4'hF, SLVERR, 0, 0);
`endif

        repeat (4) tick();
        chk("r_queue_drained", 64'(exp_r_q.size()), 0);
        chk("b_queue_drained", 64'(exp_b_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
